// File: rtl/isf_bridge_if.sv
// Master-side command/response and slave-side request signals of isf_bridge.
// The bridge uses the slave modport; the environment driving it uses the master modport.
interface isf_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              m_valid;
    logic              m_ready;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    logic [CNT_W-1:0]  m_count;

    logic              s_req;
    logic              s_write;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata, s_ack, s_rdata,
        output m_ready, m_rvalid, m_rdata, m_err, m_count,
               s_req, s_write, s_addr, s_wdata
    );

    modport master (
        output m_valid, m_write, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err, m_count,
               s_req, s_write, s_addr, s_wdata
    );
endinterface

// File: rtl/isf_bridge.sv
// FIFO-buffered command bridge: queues master commands and issues them one at a time to a slave.
// Define ISF_BRIDGE_TIMEOUT_EN to abort a slave request with m_err=1 after TIMEOUT cycles without s_ack.
module isf_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input logic         clk,
    input logic         rst,
    isf_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state, state_d;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_d;
    logic              push, pop;

    logic              s_req, s_req_d;
    logic              s_write, s_write_d;
    logic [ADDR_W-1:0] s_addr, s_addr_d;
    logic [DATA_W-1:0] s_wdata, s_wdata_d;
    logic              rvalid, rvalid_d;
    logic [DATA_W-1:0] rdata, rdata_d;

`ifdef ISF_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic              err, err_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = bus.m_valid && bus.m_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        s_req_d   = s_req;
        s_write_d = s_write;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
`ifdef ISF_BRIDGE_TIMEOUT_EN
        err_d     = err;
        tmo_cnt_d = '0;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    {s_write_d, s_addr_d, s_wdata_d} = mem[rd_ptr];
                    s_req_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack sampled on the expiry edge takes priority over the timeout.
                if (bus.s_ack) begin
                    s_req_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = s_write ? '0 : bus.s_rdata;
`ifdef ISF_BRIDGE_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = RESP;
                end
`ifdef ISF_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    s_req_d  = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage carries no reset; only pointers and occupancy define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.m_write, bus.m_addr, bus.m_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_req   <= 1'b0;
            s_write <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
`ifdef ISF_BRIDGE_TIMEOUT_EN
            err     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            state   <= state_d;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_d;
            s_req   <= s_req_d;
            s_write <= s_write_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            rvalid  <= rvalid_d;
            rdata   <= rdata_d;
`ifdef ISF_BRIDGE_TIMEOUT_EN
            err     <= err_d;
            tmo_cnt <= tmo_cnt_d;
`endif
        end
    end

    assign bus.m_ready  = (count != FULL);
    assign bus.m_count  = count;
    assign bus.m_rvalid = rvalid;
    assign bus.m_rdata  = rdata;
    assign bus.s_req    = s_req;
    assign bus.s_write  = s_write;
    assign bus.s_addr   = s_addr;
    assign bus.s_wdata  = s_wdata;
`ifdef ISF_BRIDGE_TIMEOUT_EN
    assign bus.m_err    = err;
`else
    assign bus.m_err    = 1'b0;
`endif
endmodule

// File: tb/tb_isf_bridge.sv
// Directed, table-driven bench for isf_bridge: single transactions, FIFO fill/wrap,
// asynchronous reset mid-transaction and, when ISF_BRIDGE_TIMEOUT_EN is defined, the ack timeout.
module tb_isf_bridge;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    isf_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    isf_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] srdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        bus.s_ack = 1'b1;
        tick();
        chk("idle_ack_ignored_rvalid", bus.m_rvalid, 1'b0);
        chk("idle_ack_ignored_sreq", bus.s_req, 1'b0);
        bus.s_ack   = 1'b0;
        bus.m_valid = 1'b1;
        bus.m_write = v.wr;
        bus.m_addr  = v.addr;
        bus.m_wdata = v.wdata;
        chk("m_ready_empty", bus.m_ready, 1'b1);
        tick();
        bus.m_valid = 1'b0;
        chk("count_after_push", bus.m_count, 1);
        chk("s_req_not_yet", bus.s_req, 1'b0);
        tick();
        chk("s_req_rise", bus.s_req, 1'b1);
        chk("s_addr", bus.s_addr, v.addr);
        chk("s_write", bus.s_write, v.wr);
        chk("s_wdata", bus.s_wdata, v.wdata);
        chk("count_after_pop", bus.m_count, 0);
        for (int k = 1; k < v.delay; k++) begin
            tick();
            chk("s_req_hold", bus.s_req, 1'b1);
            chk("s_addr_hold", bus.s_addr, v.addr);
            chk("rvalid_wait", bus.m_rvalid, 1'b0);
            chk("err_wait", bus.m_err, 1'b0);
        end
        bus.s_ack   = 1'b1;
        bus.s_rdata = v.srdata;
        tick();
        bus.s_ack   = 1'b0;
        bus.s_rdata = ~v.srdata;
        chk("s_req_clear", bus.s_req, 1'b0);
        chk("rvalid_pulse", bus.m_rvalid, 1'b1);
        chk("rdata", bus.m_rdata, v.exp_rdata);
        chk("err_ok", bus.m_err, 1'b0);
        tick();
        chk("rvalid_one_cycle", bus.m_rvalid, 1'b0);
        chk("rdata_held", bus.m_rdata, v.exp_rdata);
        chk("s_req_idle", bus.s_req, 1'b0);
    endtask

    task automatic service(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [31:0] srd, input logic [31:0] exp);
        int guard = 0;
        while (bus.s_req !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("svc_req_seen", bus.s_req, 1'b1);
        chk("svc_addr_order", bus.s_addr, addr);
        chk("svc_write", bus.s_write, wr);
        chk("svc_wdata", bus.s_wdata, wdata);
        bus.s_ack   = 1'b1;
        bus.s_rdata = srd;
        tick();
        bus.s_ack   = 1'b0;
        chk("svc_rvalid", bus.m_rvalid, 1'b1);
        chk("svc_rdata", bus.m_rdata, exp);
        chk("svc_err", bus.m_err, 1'b0);
        tick();
        chk("svc_rvalid_drop", bus.m_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b2b_cnt[5] = '{1, 1, 2, 3, 4};
        int nresp;
        int nreq;
        int hi;
        int guard;
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] srd;

        vecs[0] = '{1'b1, 16'h0010, 32'hA5A5_0001, 3,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{1'b0, 16'h0020, 32'h0000_0000, 1,  32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b0, 16'hFFFF, 32'h0000_0000, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 5,  32'h5555_AAAA, 32'h0000_0000};
        vecs[4] = '{1'b0, 16'h8001, 32'h0000_0000, 16, 32'hCAFE_F00D, 32'hCAFE_F00D};
`ifdef ISF_BRIDGE_TIMEOUT_EN
        vecs[5] = '{1'b0, 16'h0123, 32'h0000_0000, 1,  32'h0BAD_C0DE, 32'h0BAD_C0DE};
`else
        vecs[5] = '{1'b0, 16'h0123, 32'h0000_0000, 20, 32'h0BAD_C0DE, 32'h0BAD_C0DE};
`endif

        rst         = 1'b1;
        bus.m_valid = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        #1;
        chk("rst_m_ready", bus.m_ready, 1'b1);
        chk("rst_m_count", bus.m_count, 0);
        chk("rst_s_req", bus.s_req, 1'b0);
        chk("rst_m_rvalid", bus.m_rvalid, 1'b0);
        chk("rst_m_err", bus.m_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", bus.m_ready, 1'b1);
        chk("post_rst_s_req", bus.s_req, 1'b0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Fill: first command goes straight to REQ, the remaining four fill the FIFO and wrap it.
        for (int i = 0; i < 5; i++) begin
            chk("b2b_ready", bus.m_ready, 1'b1);
            bus.m_valid = 1'b1;
            bus.m_write = i[0];
            bus.m_addr  = 16'(16'h0100 + i);
            bus.m_wdata = 32'(32'h1000_0000 + i);
            tick();
            chk("b2b_count", bus.m_count, b2b_cnt[i]);
        end
        bus.m_valid = 1'b0;
        chk("b2b_full_ready", bus.m_ready, 1'b0);
        chk("b2b_req_active", bus.s_req, 1'b1);
        for (int j = 0; j < 5; j++) begin
            wr  = j[0];
            a   = 16'(16'h0100 + j);
            d   = 32'(32'h1000_0000 + j);
            srd = 32'(32'h5000_0000 + j);
            service(wr, a, d, srd, wr ? 32'h0 : srd);
        end
        chk("b2b_drained", bus.m_count, 0);

`ifdef ISF_BRIDGE_TIMEOUT_EN
        bus.m_valid = 1'b1;
        bus.m_write = 1'b0;
        bus.m_addr  = 16'h0300;
        tick();
        bus.m_valid = 1'b0;
        tick();
        hi    = 0;
        guard = 0;
        while (bus.s_req === 1'b1 && guard < 40) begin
            hi++;
            guard++;
            tick();
        end
        chk("tmo_req_cycles", hi, TIMEOUT);
        chk("tmo_rvalid", bus.m_rvalid, 1'b1);
        chk("tmo_err", bus.m_err, 1'b1);
        chk("tmo_rdata", bus.m_rdata, 32'h0);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'hFFFF_FFFF;
        tick();
        chk("tmo_late_ack_rvalid", bus.m_rvalid, 1'b0);
        chk("tmo_err_held", bus.m_err, 1'b1);
        chk("tmo_rdata_held", bus.m_rdata, 32'h0);
        tick();
        chk("tmo_late_ack_idle", bus.m_rvalid, 1'b0);
        bus.s_ack = 1'b0;
`endif

        // Asynchronous reset with one command in REQ and two queued.
        for (int i = 0; i < 3; i++) begin
            bus.m_valid = 1'b1;
            bus.m_write = 1'b0;
            bus.m_addr  = 16'(16'h0200 + i);
            bus.m_wdata = 32'(32'h2000_0000 + i);
            tick();
        end
        bus.m_valid = 1'b0;
        chk("pre_rst_count", bus.m_count, 2);
        chk("pre_rst_s_req", bus.s_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_s_req", bus.s_req, 1'b0);
        chk("async_rst_count", bus.m_count, 0);
        chk("async_rst_rvalid", bus.m_rvalid, 1'b0);
        chk("async_rst_ready", bus.m_ready, 1'b1);
        chk("async_rst_s_addr", bus.s_addr, 16'h0);
        chk("async_rst_rdata", bus.m_rdata, 32'h0);
        tick();
        rst = 1'b0;
        nresp     = 0;
        nreq      = 0;
        bus.s_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.m_rvalid === 1'b1) nresp++;
            if (bus.s_req === 1'b1) nreq++;
        end
        bus.s_ack = 1'b0;
        chk("no_resp_after_rst", nresp, 0);
        chk("no_req_after_rst", nreq, 0);
        chk("empty_after_rst", bus.m_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/isf_bridge.md
ISF_BRIDGE -- requirements
Module: isf_bridge

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 16, address width; DATA_W, default 32, data width; DEPTH, default 4, command FIFO entries; TIMEOUT, default 16, slave-ack wait limit in cycles.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port rst  in  1  asynchronous active-high reset.
REQ-004 The block SHALL have port m_valid  in  1  master command valid.
REQ-005 The block SHALL have port m_ready  out  1  command FIFO can accept.
REQ-006 The block SHALL have port m_write  in  1  1=write, 0=read.
REQ-007 The block SHALL have port m_addr  in  ADDR_W  command address.
REQ-008 The block SHALL have port m_wdata  in  DATA_W  write data.
REQ-009 The block SHALL have port m_rvalid  out  1  one-cycle response strobe.
REQ-010 The block SHALL have port m_rdata  out  DATA_W  response data.
REQ-011 The block SHALL have port m_err  out  1  response error flag, valid with m_rvalid.
REQ-012 The block SHALL have port m_count  out  clog2(DEPTH+1)  FIFO occupancy.
REQ-013 The block SHALL have ports s_req  out  1; s_write  out  1; s_addr  out  ADDR_W; s_wdata  out  DATA_W (slave request bundle).
REQ-014 The block SHALL have ports s_ack  in  1  slave completion; s_rdata  in  DATA_W  slave read data.

Function
REQ-015 m_ready SHALL equal (m_count != DEPTH), combinational; a command is accepted on a rising edge with m_valid && m_ready.
REQ-016 Accepted commands SHALL be stored in a DEPTH-entry FIFO and issued strictly in order; push and pop in the same cycle leave m_count unchanged; pointers wrap modulo DEPTH.
REQ-017 Control FSM states SHALL be IDLE, REQ, RESP.
REQ-018 IDLE: when FIFO non-empty, pop head at the edge, register s_write/s_addr/s_wdata, set s_req=1, go to REQ; otherwise stay.
REQ-019 REQ: s_req and the s_* bundle SHALL stay stable until s_ack is sampled high; at that edge s_req clears, m_rvalid=1, m_err=0, m_rdata=s_rdata for reads or 0 for writes, go to RESP.
REQ-020 RESP: m_rvalid SHALL be high for exactly this one cycle; next edge clears m_rvalid, go to IDLE.
REQ-021 Minimum latency: command accepted into an empty FIFO at edge N drives s_req high after edge N+1; ack at edge K gives m_rvalid high after edge K.
REQ-022 s_ack SHALL be ignored in IDLE and RESP.
REQ-023 m_rdata and m_err SHALL hold their values until the next response.

Reset
REQ-024 rst high SHALL immediately clear m_count, FIFO pointers, s_req, s_write, s_addr, s_wdata, m_rvalid, m_rdata, m_err to 0 and force IDLE; FIFO contents and any in-flight transaction are discarded; m_ready=1 during and after reset.

Configuration
REQ-025 With ISF_BRIDGE_TIMEOUT_EN defined, a cycle counter SHALL run in REQ; if no s_ack after TIMEOUT cycles of s_req high, s_req SHALL clear and a response SHALL issue with m_err=1, m_rdata=0, then go to RESP; an ack coinciding with the expiry edge wins (m_err=0).
REQ-026 Without ISF_BRIDGE_TIMEOUT_EN, REQ SHALL wait indefinitely and m_err SHALL be constant 0.

Verification
REQ-027 Reset then write addr 0x0010 data 0xA5A5_0001, ack after 3 cycles -> s_req high 3 cycles with s_addr=0x0010, one m_rvalid with m_rdata=0, m_err=0.
REQ-028 Read addr 0x0020, slave returns 0x1234_5678 on ack -> m_rvalid one cycle with m_rdata=0x1234_5678.
REQ-029 Push 5 commands back-to-back with s_ack held low -> m_count reaches 4 (one popped into REQ), m_ready=0; release ack -> 5 responses in push order.
REQ-030 Assert rst while s_req high with 2 queued -> s_req, m_count, m_rvalid 0 asynchronously; no responses after release.
REQ-031 ISF_BRIDGE_TIMEOUT_EN defined, s_ack never asserted -> s_req high exactly 16 cycles, then m_rvalid with m_err=1, m_rdata=0; a later s_ack is ignored.
